// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide UART transmitter fed by a small FIFO.
// Bytes enter through a valid/ready handshake and are queued. Each byte is
// moved into a shift register and sent LSB-first as an 8N1 frame, or as an
// 8E1 frame when PARITY_EN is set. Consecutive frames follow each other with
// no idle gap. The serial output comes straight from a flop.
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter bit PARITY_EN   = 1'b0,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   usage_o
);

    localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    // Reject parameter sets the datapath cannot support.
    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_fifo: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;

    // Transmitter state
    state_e        state_q, state_d;
    logic [BW-1:0] baud_q,  baud_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q,   par_d;
    logic          tx_q,    tx_d;

    logic          push;
    logic          pop;
    logic          baud_last;
    logic          fifo_has_data;
    logic [7:0]    head_byte;

    assign ready_o       = (cnt_q != FULL_CNT);
    assign usage_o       = cnt_q;
    assign busy_o        = (state_q != S_IDLE);
    assign tx_o          = tx_q;

    assign push          = valid_i && ready_o;
    assign fifo_has_data = (cnt_q != '0);
    assign baud_last     = (baud_q == BAUD_LAST);
    assign head_byte     = mem[rptr_q];

    // A byte leaves the FIFO when the line is idle, or on the final stop-bit
    // cycle so the next start bit follows without a gap.
    assign pop = fifo_has_data &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));

    // FIFO write port; the storage itself is never reset, only the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr_q] <= data_i;
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Next-state logic: frame sequencing, baud timing and shifter updates.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (pop) begin
                    state_d = S_START;
                    shift_d = head_byte;
                    par_d   = ^head_byte;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (pop) begin
                        state_d = S_START;
                        shift_d = head_byte;
                        par_d   = ^head_byte;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level for the coming cycle, taken from the state being entered so
    // the registered output lines up with the state register.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // Transmitter registers; reset forces the line high immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: two instances (8N1 and 8E1), both with DIV=8 and
// a 4-entry FIFO. A queue-based model predicts every output after each clock
// edge, and a line monitor decodes frames into characters.
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 921600;
    localparam int BAUD   = 115200;
    localparam int DIV    = 8;
    localparam int DEPTH  = 4;
    localparam int UW     = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    d0 = 8'h00, dp = 8'h00;
    logic          v0 = 1'b0,  vp = 1'b0;
    logic          tx0, busy0, ready0, txp, busyp, readyp;
    logic [UW-1:0] usage0, usagep;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_EN(1'b0), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(d0), .valid_i(v0), .ready_o(ready0),
        .tx_o(tx0), .busy_o(busy0), .usage_o(usage0)
    );

    uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_EN(1'b1), .FIFO_DEPTH(DEPTH)) dut_p (
        .clk_i(clk), .rst_i(rst), .data_i(dp), .valid_i(vp), .ready_o(readyp),
        .tx_o(txp), .busy_o(busyp), .usage_o(usagep)
    );

    // Outputs of the instance currently under test
    bit            sel = 1'b0;
    logic          s_tx, s_busy, s_ready;
    logic [UW-1:0] s_usage;
    logic [5:0]    obs;
    assign s_tx    = sel ? txp    : tx0;
    assign s_busy  = sel ? busyp  : busy0;
    assign s_ready = sel ? readyp : ready0;
    assign s_usage = sel ? usagep : usage0;
    assign obs     = {s_tx, s_busy, s_ready, s_usage};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Reference model: a byte queue plus the edge at which the transmitter
    // can next take a byte. A frame started at edge s occupies the FL cycles
    // after edges s .. s+FL-1.
    // ------------------------------------------------------------------
    logic [7:0] m_fifo[$];
    logic [7:0] m_sent[$];
    logic [7:0] m_cur;
    int         m_edge, m_free, m_start;
    bit         m_par, m_acc;

    function automatic void model_reset(input bit par);
        m_fifo.delete();
        m_sent.delete();
        m_cur   = 8'h00;
        m_edge  = 0;
        m_free  = 0;
        m_start = 0;
        m_par   = par;
        m_acc   = 1'b0;
    endfunction

    function automatic void model_edge(input logic v, input logic [7:0] d);
        int fl;
        fl    = m_par ? 11 * DIV : 10 * DIV;
        m_acc = v && (m_fifo.size() < DEPTH);
        m_edge++;
        if (m_fifo.size() > 0 && m_edge >= m_free) begin
            m_cur   = m_fifo.pop_front();
            m_start = m_edge;
            m_free  = m_edge + fl;
            m_sent.push_back(m_cur);
        end
        if (m_acc) m_fifo.push_back(d);
    endfunction

    // Bit idx of a frame: start, 8 data bits LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] d, input bit par, input int idx);
        if (idx == 0)            return 1'b0;
        else if (idx <= 8)       return d[idx-1];
        else if (par && idx == 9) return ^d;
        else                     return 1'b1;
    endfunction

    function automatic logic [5:0] exp_vec();
        logic          busy_e, tx_e, ready_e;
        logic [UW-1:0] u;
        busy_e  = (m_edge < m_free);
        tx_e    = busy_e ? frame_bit(m_cur, m_par, (m_edge - m_start) / DIV) : 1'b1;
        ready_e = (m_fifo.size() != DEPTH);
        u       = UW'(m_fifo.size());
        return {tx_e, busy_e, ready_e, u};
    endfunction

    // One clock: drive inputs, advance the model at the edge, return at the
    // following falling edge where outputs are sampled.
    task automatic tick(input logic v, input logic [7:0] d);
        if (sel) begin vp = v; dp = d; end
        else     begin v0 = v; d0 = d; end
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        v0 = 1'b0;
        vp = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // UART line monitor: decodes frames, checks every bit holds for DIV
    // cycles, abandons a frame on reset.
    // ------------------------------------------------------------------
    typedef struct {
        bit         w;
        logic [7:0] data;
        logic       par;
        logic       stop;
        bit         stable;
        int         start;
    } rx_t;
    rx_t rx_q[$];

    function automatic logic line(input bit w);
        return w ? txp : tx0;
    endfunction

    task automatic monitor(input bit w);
        int          nb;
        logic [10:0] bits;
        bit          stable, aborted;
        int          st;
        rx_t         r;
        nb = w ? 11 : 10;
        forever begin
            @(negedge clk);
            if (!rst && line(w) === 1'b0) begin
                st      = cyc;
                stable  = 1'b1;
                aborted = 1'b0;
                bits    = '1;
                for (int b = 0; b < nb && !aborted; b++) begin
                    for (int k = 0; k < DIV && !aborted; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (rst)            aborted = 1'b1;
                        else if (k == 0)    bits[b] = line(w);
                        else if (line(w) !== bits[b]) stable = 1'b0;
                    end
                end
                if (!aborted) begin
                    r.w      = w;
                    r.data   = bits[8:1];
                    r.par    = w ? bits[9] : 1'b0;
                    r.stop   = bits[nb-1];
                    r.stable = stable;
                    r.start  = st;
                    rx_q.push_back(r);
                    $display("[UART%0d] rx 0x%02h par=%0b stop=%0b stable=%0b start_cyc=%0d",
                             w, r.data, r.par, r.stop, r.stable, r.start);
                end
            end
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sel = w[0];
            #1;
            n_cmp++; if (s_tx !== 1'b1)     begin n_bad++; $display("FAIL reset_tx[%0d]: got %b want 1", w, s_tx); end
            n_cmp++; if (s_busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", w, s_busy); end
            n_cmp++; if (s_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 1", w, s_ready); end
            n_cmp++; if (s_usage !== 3'd0)  begin n_bad++; $display("FAIL reset_usage[%0d]: got %0d want 0", w, s_usage); end
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b0;
        $display("[TB] reset checks done");
    endtask

    task automatic test_single_byte();
        int busy_cnt = 0;
        int base;
        sel = 1'b0;
        model_reset(1'b0);
        base = rx_q.size();
        for (int i = 0; i < 95; i++) begin
            tick(i == 0, 8'h41);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL single_byte edge %0d: {tx,busy,ready,usage} got %b want %b", m_edge, obs, exp_vec());
            end
            if (i == 0) begin
                n_cmp++; if (s_usage !== 3'd1 || s_tx !== 1'b1) begin n_bad++; $display("FAIL single_push_latency: usage=%0d tx=%b want usage=1 tx=1", s_usage, s_tx); end
            end
            if (i == 1) begin
                n_cmp++; if (s_tx !== 1'b0 || s_busy !== 1'b1 || s_usage !== 3'd0) begin n_bad++; $display("FAIL single_pop_latency: tx=%b busy=%b usage=%0d want 0/1/0", s_tx, s_busy, s_usage); end
            end
            if (s_busy === 1'b1) busy_cnt++;
        end
        n_cmp++; if (busy_cnt != 80) begin n_bad++; $display("FAIL single_busy_len: got %0d want 80", busy_cnt); end
        n_cmp++;
        if (rx_q.size() != base + 1 || rx_q[base].data !== 8'h41 || !rx_q[base].stable || rx_q[base].stop !== 1'b1) begin
            n_bad++;
            $display("FAIL single_rx: got %0d frames want 1 frame of 0x41", rx_q.size() - base);
        end
        $display("[TB] single byte 0x41 done, busy %0d cycles", busy_cnt);
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [3] = '{8'h48, 8'h69, 8'h0A};
        int    busy_cnt = 0;
        int    base;
        string s;
        sel = 1'b0;
        model_reset(1'b0);
        base = rx_q.size();
        for (int i = 0; i < 260; i++) begin
            tick(i < 3, msg[i % 3]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL back_to_back edge %0d: {tx,busy,ready,usage} got %b want %b", m_edge, obs, exp_vec());
            end
            if (s_busy === 1'b1) busy_cnt++;
        end
        n_cmp++; if (busy_cnt != 240) begin n_bad++; $display("FAIL b2b_busy_len: got %0d want 240", busy_cnt); end
        n_cmp++;
        if (rx_q.size() != base + 3) begin
            n_bad++;
            $display("FAIL b2b_rx_count: got %0d want 3", rx_q.size() - base);
        end else begin
            s = "";
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (rx_q[base+k].data !== msg[k] || !rx_q[base+k].stable) begin
                    n_bad++;
                    $display("FAIL b2b_rx[%0d]: got 0x%02h want 0x%02h", k, rx_q[base+k].data, msg[k]);
                end
                if (k > 0) begin
                    n_cmp++;
                    if (rx_q[base+k].start - rx_q[base+k-1].start != 80) begin
                        n_bad++;
                        $display("FAIL b2b_gap[%0d]: got %0d cycles want 80", k, rx_q[base+k].start - rx_q[base+k-1].start);
                    end
                end
                if (k < 2) s = $sformatf("%s%c", s, rx_q[base+k].data);
            end
            $display("[UART]: %s", s);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] next = 8'h00;
        int acc_cnt = 0;
        int first_ready = -1;
        int base;
        sel = 1'b0;
        model_reset(1'b0);
        base = rx_q.size();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, next);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL fifo_full edge %0d: {tx,busy,ready,usage} got %b want %b", m_edge, obs, exp_vec());
            end
            if (m_acc) begin acc_cnt++; next++; end
            if (i == 4) begin
                n_cmp++;
                if (acc_cnt != 5 || s_usage !== 3'd4 || s_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL fifo_full_stall: accepted=%0d usage=%0d ready=%b want 5/4/0", acc_cnt, s_usage, s_ready);
                end
            end
        end
        for (int i = 0; i < 450; i++) begin
            tick(1'b0, 8'h00);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL fifo_drain edge %0d: {tx,busy,ready,usage} got %b want %b", m_edge, obs, exp_vec());
            end
            if (first_ready < 0 && s_ready === 1'b1) first_ready = m_edge;
        end
        n_cmp++; if (first_ready != 2 + 10 * DIV) begin n_bad++; $display("FAIL fifo_ready_return: got edge %0d want %0d", first_ready, 2 + 10 * DIV); end
        n_cmp++;
        if (rx_q.size() != base + 5) begin
            n_bad++;
            $display("FAIL fifo_rx_count: got %0d want 5", rx_q.size() - base);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (rx_q[base+k].data !== 8'(k)) begin
                    n_bad++;
                    $display("FAIL fifo_rx_order[%0d]: got 0x%02h want 0x%02h", k, rx_q[base+k].data, 8'(k));
                end
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] pat [2] = '{8'h07, 8'h03};
        logic       pb  [2] = '{1'b1, 1'b0};
        int busy_cnt = 0;
        int base;
        sel = 1'b1;
        model_reset(1'b1);
        base = rx_q.size();
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 100; i++) begin
                tick(i == 0, pat[j]);
                n_cmp++;
                if (obs !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL parity edge %0d: {tx,busy,ready,usage} got %b want %b", m_edge, obs, exp_vec());
                end
                if (j == 0 && s_busy === 1'b1) busy_cnt++;
            end
        end
        n_cmp++; if (busy_cnt != 88) begin n_bad++; $display("FAIL parity_frame_len: got %0d want 88", busy_cnt); end
        n_cmp++;
        if (rx_q.size() != base + 2) begin
            n_bad++;
            $display("FAIL parity_rx_count: got %0d want 2", rx_q.size() - base);
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (rx_q[base+k].data !== pat[k] || rx_q[base+k].par !== pb[k] ||
                    (^rx_q[base+k].data ^ rx_q[base+k].par) !== 1'b0 || rx_q[base+k].stop !== 1'b1) begin
                    n_bad++;
                    $display("FAIL parity_rx[%0d]: got data 0x%02h par %b want 0x%02h par %b",
                             k, rx_q[base+k].data, rx_q[base+k].par, pat[k], pb[k]);
                end
            end
        end
    endtask

    task automatic test_random(input bit w);
        int base;
        int guard = 0;
        logic v;
        logic [7:0] d;
        sel = w;
        model_reset(w);
        base = rx_q.size();
        for (int i = 0; i < 250; i++) begin
            v = ($urandom_range(0, 99) < 35);
            d = 8'($urandom);
            tick(v, d);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL random[%0d] edge %0d: {tx,busy,ready,usage} got %b want %b", w, m_edge, obs, exp_vec());
            end
        end
        while ((m_fifo.size() > 0 || m_edge < m_free) && guard < 1000) begin
            tick(1'b0, 8'h00);
            guard++;
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_drain[%0d] edge %0d: {tx,busy,ready,usage} got %b want %b", w, m_edge, obs, exp_vec());
            end
        end
        n_cmp++; if (guard >= 1000) begin n_bad++; $display("FAIL random_drain_timeout[%0d]: waited %0d cycles", w, guard); end
        tick(1'b0, 8'h00);
        n_cmp++;
        if (rx_q.size() - base != m_sent.size()) begin
            n_bad++;
            $display("FAIL random_rx_count[%0d]: got %0d want %0d", w, rx_q.size() - base, m_sent.size());
        end else begin
            for (int k = 0; k < m_sent.size(); k++) begin
                n_cmp++;
                if (rx_q[base+k].data !== m_sent[k] || !rx_q[base+k].stable || rx_q[base+k].stop !== 1'b1 ||
                    (w && rx_q[base+k].par !== ^m_sent[k])) begin
                    n_bad++;
                    $display("FAIL random_rx[%0d][%0d]: got 0x%02h want 0x%02h", w, k, rx_q[base+k].data, m_sent[k]);
                end
            end
        end
        $display("[TB] random run on instance %0d: %0d frames", w, m_sent.size());
    endtask

    task automatic test_reset_midframe();
        logic [7:0] bytes [3] = '{8'hA5, 8'h5A, 8'hC3};
        int base;
        int guard = 0;
        sel = 1'b0;
        model_reset(1'b0);
        base = rx_q.size();
        for (int i = 0; i < 3; i++) tick(1'b1, bytes[i]);
        // run into data bit 3 of the first frame
        while (!(m_edge < m_free && (m_edge - m_start) == DIV * 4 + 3) && guard < 200) begin
            tick(1'b0, 8'h00);
            guard++;
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL midframe_pre edge %0d: {tx,busy,ready,usage} got %b want %b", m_edge, obs, exp_vec());
            end
        end
        n_cmp++; if (s_tx !== 1'b0 || s_usage !== 3'd2) begin n_bad++; $display("FAIL midframe_setup: tx=%b usage=%0d want 0/2", s_tx, s_usage); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (tx0 !== 1'b1)    begin n_bad++; $display("FAIL async_reset_tx: got %b want 1", tx0); end
        n_cmp++; if (busy0 !== 1'b0)  begin n_bad++; $display("FAIL async_reset_busy: got %b want 0", busy0); end
        n_cmp++; if (usage0 !== 3'd0) begin n_bad++; $display("FAIL async_reset_usage: got %0d want 0", usage0); end
        n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL async_reset_ready: got %b want 1", ready0); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset(1'b0);
        for (int i = 0; i < 200; i++) begin
            tick(1'b0, 8'h00);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL after_reset edge %0d: {tx,busy,ready,usage} got %b want %b", m_edge, obs, exp_vec());
            end
        end
        n_cmp++; if (rx_q.size() != base) begin n_bad++; $display("FAIL after_reset_rx: got %0d frames want 0", rx_q.size() - base); end
        $display("[TB] reset mid-frame done");
    endtask

    initial begin
        model_reset(1'b0);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fifo_full();
        test_parity();
        test_random(1'b0);
        test_random(1'b1);
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
